bv_emulator: RTL

- Validator-side responder for the CCNET bill-validator link. It stands in for a real validator on the bench and in field loopback, answering the host controller's poll, reset, ACK and enable-bill-types frames.
- Sits behind the existing async_receiver/async_transmitter pair (19200 baud, CLK_10MHZ) and talks to them at byte level.
- A front-panel/test input injects bill insertions. The emulator walks the validator status sequence and reports the stacked bill code to the host.

---
 rtl/bv_pkg.sv | 39 +++
 rtl/ccnet_crc16.sv | 34 +++
 rtl/bv_emulator.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/bv_pkg.sv
// Shared constants, state encodings and CRC step for the CCNET bill-validator emulator.
package bv_pkg;

    // Host command codes (also reused as reply command bytes)
    localparam logic [7:0] CMD_ACK     = 8'h00;
    localparam logic [7:0] CMD_RESET   = 8'h30;
    localparam logic [7:0] CMD_POLL    = 8'h33;
    localparam logic [7:0] CMD_ENABLE  = 8'h34;
    localparam logic [7:0] CMD_NAK     = 8'hFF;
    localparam logic [7:0] RSP_ILLEGAL = 8'h30;

    // Validator status codes reported in POLL replies
    localparam logic [7:0] ST_POWERUP  = 8'h10;
    localparam logic [7:0] ST_INIT     = 8'h13;
    localparam logic [7:0] ST_IDLE     = 8'h14;
    localparam logic [7:0] ST_ACCEPT   = 8'h15;
    localparam logic [7:0] ST_STACKING = 8'h17;
    localparam logic [7:0] ST_DISABLED = 8'h19;
    localparam logic [7:0] ST_REJECT   = 8'h1C;
    localparam logic [7:0] ST_STACKED  = 8'h81;

    localparam logic [7:0]  REJECT_REASON = 8'h66;
    localparam logic [7:0]  SYNC_BYTE     = 8'h02;
    localparam logic [15:0] CRC_POLY      = 16'h8408;

    typedef enum logic [2:0] {RX_HUNT, RX_ADR, RX_LNG, RX_BODY, RX_CHECK} rx_state_t;
    typedef enum logic [1:0] {TX_IDLE, TX_GAP, TX_SEND} tx_state_t;

    // One byte of the reflected CCNET CRC-16
    function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data);
        logic [15:0] c;
        c = crc_in ^ {8'h00, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/ccnet_crc16.sv
// Bytewise CCNET CRC-16 accumulator. Clear and enable may coincide so the
// first byte of a frame can be folded in on the same cycle the CRC restarts.
module ccnet_crc16
    import bv_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_clr,
    input  logic        i_en,
    input  logic [7:0]  i_data,
    output logic [15:0] o_crc
);

    logic [15:0] r_crc;
    logic [15:0] w_base;
    logic [15:0] w_next;

    assign w_base = i_clr ? 16'h0000 : r_crc;
    assign w_next = crc16_byte(w_base, i_data);

    // Accumulate one byte per enable, restart on clear
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_crc <= 16'h0000;
        end else if (i_en) begin
            r_crc <= w_next;
        end else if (i_clr) begin
            r_crc <= 16'h0000;
        end
    end

    assign o_crc = r_crc;

endmodule

// File: rtl/bv_emulator.sv
// CCNET bill-validator responder: parses host frames, tracks validator status,
// and answers through a byte-level transmitter handshake (half duplex).
module bv_emulator
    import bv_pkg::*;
#(
    parameter logic [7:0] ADDR         = 8'h03,
    parameter int         TIMEOUT_CYC  = 50000,
    parameter int         RESP_GAP_CYC = 20000,
    parameter int         MAX_LNG      = 16
) (
    input  logic       CLK_10MHZ,
    input  logic       RST,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    output logic [7:0] tx_data,
    output logic       tx_start,
    input  logic       tx_busy,
    input  logic       bill_insert,
    input  logic [4:0] bill_code,
    output logic [7:0] bv_state,
    output logic       bill_pending,
    output logic [7:0] crc_err_cnt
);

    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam int GAP_W = $clog2(RESP_GAP_CYC + 1);
    localparam logic [TO_W-1:0]  TO_LAST    = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST   = GAP_W'(RESP_GAP_CYC - 1);
    localparam logic [7:0]       MAX_LNG_B  = 8'(MAX_LNG);

    // ---------------- receive side ----------------
    rx_state_t         r_rx_state;
    logic              r_rx_ready_d;
    logic [4:0]        r_byte_idx;
    logic [4:0]        r_lng;
    logic [7:0]        r_cmd, r_d0, r_d1, r_d2, r_crc_lo, r_crc_hi;
    logic [TO_W-1:0]   r_idle_cnt;
    logic [15:0]       w_rx_crc;
    logic [4:0]        w_crc_lo_idx;
    logic              w_rx_stb, w_rx_crc_en, w_rx_crc_clr;

    // ---------------- status / control ----------------
    logic [7:0]  r_bv_state;
    logic [23:0] r_mask;
    logic        r_pending;
    logic [4:0]  r_code;
    logic [7:0]  r_crc_err;
    logic [23:0] w_new_mask;
    logic [31:0] w_mask_ext;
    logic        w_check, w_crc_ok, w_good, w_bad;
    logic        w_cmd_reset, w_cmd_poll, w_cmd_enable, w_cmd_ack, w_reply_now;
    logic [2:0]  w_rep_len;
    logic [7:0]  w_rep_b0, w_rep_b1;

    // ---------------- transmit side ----------------
    tx_state_t        r_tx_state;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [2:0]       r_tx_idx, r_rep_len;
    logic [7:0]       r_rep_b0, r_rep_b1, r_tx_data;
    logic             r_tx_start, r_tx_busy_d;
    logic [15:0]      w_tx_crc;
    logic [7:0]       w_tx_byte;
    logic             w_tx_active, w_tx_launch;

    assign w_tx_active  = (r_tx_state != TX_IDLE);
    assign w_rx_stb     = rx_ready & ~r_rx_ready_d & ~w_tx_active;
    assign w_crc_lo_idx = r_lng - 5'd2;

    // CRC covers 02..last data byte; CRC bytes themselves are excluded
    assign w_rx_crc_clr = (r_rx_state == RX_HUNT);
    assign w_rx_crc_en  = w_rx_stb &&
                          (((r_rx_state == RX_HUNT) && (rx_data == SYNC_BYTE)) ||
                           (r_rx_state == RX_ADR) || (r_rx_state == RX_LNG) ||
                           ((r_rx_state == RX_BODY) && (r_byte_idx < w_crc_lo_idx)));

    ccnet_crc16 u_rx_crc (
        .clk    (CLK_10MHZ),
        .rst    (RST),
        .i_clr  (w_rx_crc_clr),
        .i_en   (w_rx_crc_en),
        .i_data (rx_data),
        .o_crc  (w_rx_crc)
    );

    // Edge detector for the receiver's level data_ready
    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) r_rx_ready_d <= 1'b0;
        else     r_rx_ready_d <= rx_ready;
    end

    // Receive FSM: frame parsing, field capture and inter-byte timeout
    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            r_rx_state <= RX_HUNT;
            r_byte_idx <= 5'd0;
            r_lng      <= 5'd0;
            r_cmd      <= 8'h00;
            r_d0       <= 8'h00;
            r_d1       <= 8'h00;
            r_d2       <= 8'h00;
            r_crc_lo   <= 8'h00;
            r_crc_hi   <= 8'h00;
            r_idle_cnt <= '0;
        end else if (w_tx_active) begin
            r_rx_state <= RX_HUNT;
            r_idle_cnt <= '0;
        end else begin
            case (r_rx_state)
                RX_HUNT: begin
                    r_idle_cnt <= '0;
                    if (w_rx_stb && (rx_data == SYNC_BYTE)) begin
                        r_rx_state <= RX_ADR;
                        r_cmd      <= 8'h00;
                        r_d0       <= 8'h00;
                        r_d1       <= 8'h00;
                        r_d2       <= 8'h00;
                    end
                end
                RX_CHECK: r_rx_state <= RX_HUNT;
                default: begin
                    if (w_rx_stb) begin
                        r_idle_cnt <= '0;
                        if (r_rx_state == RX_ADR) begin
                            r_rx_state <= (rx_data == ADDR) ? RX_LNG : RX_HUNT;
                        end else if (r_rx_state == RX_LNG) begin
                            if ((rx_data < 8'd6) || (rx_data > MAX_LNG_B)) begin
                                r_rx_state <= RX_HUNT;
                            end else begin
                                r_lng      <= rx_data[4:0];
                                r_byte_idx <= 5'd3;
                                r_rx_state <= RX_BODY;
                            end
                        end else begin
                            r_byte_idx <= r_byte_idx + 5'd1;
                            if (r_byte_idx < w_crc_lo_idx) begin
                                case (r_byte_idx)
                                    5'd3:    r_cmd <= rx_data;
                                    5'd4:    r_d0  <= rx_data;
                                    5'd5:    r_d1  <= rx_data;
                                    5'd6:    r_d2  <= rx_data;
                                    default: ;
                                endcase
                            end else if (r_byte_idx == w_crc_lo_idx) begin
                                r_crc_lo <= rx_data;
                            end else begin
                                r_crc_hi   <= rx_data;
                                r_rx_state <= RX_CHECK;
                            end
                        end
                    end else if (r_idle_cnt == TO_LAST) begin
                        r_rx_state <= RX_HUNT;
                    end else begin
                        r_idle_cnt <= r_idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

    // Frame decode during the single CHECK cycle
    assign w_check      = (r_rx_state == RX_CHECK);
    assign w_crc_ok     = (w_rx_crc == {r_crc_hi, r_crc_lo});
    assign w_good       = w_check & w_crc_ok;
    assign w_bad        = w_check & ~w_crc_ok;
    assign w_cmd_reset  = w_good && (r_cmd == CMD_RESET);
    assign w_cmd_poll   = w_good && (r_cmd == CMD_POLL);
    assign w_cmd_enable = w_good && (r_cmd == CMD_ENABLE);
    assign w_cmd_ack    = w_good && (r_cmd == CMD_ACK);
    assign w_reply_now  = w_bad || (w_good && (r_cmd != CMD_ACK));
    assign w_new_mask   = {r_d0, r_d1, r_d2};
    assign w_mask_ext   = {8'h00, r_mask};

    // Reply contents, snapshotted from the status before any advance
    always_comb begin
        w_rep_len = 3'd6;
        w_rep_b0  = RSP_ILLEGAL;
        w_rep_b1  = 8'h00;
        if (w_bad) begin
            w_rep_b0 = CMD_NAK;
        end else if ((r_cmd == CMD_RESET) || (r_cmd == CMD_ENABLE)) begin
            w_rep_b0 = CMD_ACK;
        end else if (r_cmd == CMD_POLL) begin
            w_rep_b0 = r_bv_state;
            if (r_bv_state == ST_STACKED) begin
                w_rep_len = 3'd7;
                w_rep_b1  = {3'b000, r_code};
            end else if (r_bv_state == ST_REJECT) begin
                w_rep_len = 3'd7;
                w_rep_b1  = REJECT_REASON;
            end
        end
    end

    // Validator status machine, enable mask, pending bill and CRC error count
    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            r_bv_state <= ST_POWERUP;
            r_mask     <= 24'h0;
            r_pending  <= 1'b0;
            r_code     <= 5'd0;
            r_crc_err  <= 8'h00;
        end else begin
            if (w_bad && (r_crc_err != 8'hFF)) r_crc_err <= r_crc_err + 8'd1;
            if (w_cmd_reset) begin
                r_bv_state <= ST_POWERUP;
                r_mask     <= 24'h0;
                r_pending  <= 1'b0;
            end else if (w_cmd_enable) begin
                r_mask <= w_new_mask;
                if ((r_bv_state == ST_DISABLED) || (r_bv_state == ST_IDLE))
                    r_bv_state <= (w_new_mask != 24'h0) ? ST_IDLE : ST_DISABLED;
            end else if (w_cmd_poll) begin
                case (r_bv_state)
                    ST_POWERUP:  r_bv_state <= ST_INIT;
                    ST_INIT:     r_bv_state <= (r_mask == 24'h0) ? ST_DISABLED : ST_IDLE;
                    ST_ACCEPT:   r_bv_state <= ST_STACKING;
                    ST_STACKING: begin
                        r_bv_state <= ST_STACKED;
                        r_pending  <= 1'b1;
                    end
                    default: ;
                endcase
            end else if (w_cmd_ack) begin
                if (r_bv_state == ST_STACKED) begin
                    r_pending  <= 1'b0;
                    r_bv_state <= ST_IDLE;
                end else if (r_bv_state == ST_REJECT) begin
                    r_bv_state <= ST_IDLE;
                end
            end
            // Bill insertion only from idle; RESET/ENABLE in the same cycle take precedence
            if (bill_insert && (r_bv_state == ST_IDLE) && !w_cmd_reset && !w_cmd_enable) begin
                if (w_mask_ext[bill_code]) begin
                    r_bv_state <= ST_ACCEPT;
                    r_code     <= bill_code;
                end else begin
                    r_bv_state <= ST_REJECT;
                end
            end
        end
    end

    // Byte selector for the outgoing frame: header, payload, then running CRC
    always_comb begin
        w_tx_byte = r_rep_b1;
        case (r_tx_idx)
            3'd0: w_tx_byte = SYNC_BYTE;
            3'd1: w_tx_byte = ADDR;
            3'd2: w_tx_byte = {5'b00000, r_rep_len};
            3'd3: w_tx_byte = r_rep_b0;
            default: begin
                if (r_tx_idx == (r_rep_len - 3'd2))      w_tx_byte = w_tx_crc[7:0];
                else if (r_tx_idx == (r_rep_len - 3'd1)) w_tx_byte = w_tx_crc[15:8];
            end
        endcase
    end

    assign w_tx_launch = (r_tx_state == TX_SEND) && !r_tx_start && !tx_busy &&
                         !r_tx_busy_d && (r_tx_idx != r_rep_len);

    ccnet_crc16 u_tx_crc (
        .clk    (CLK_10MHZ),
        .rst    (RST),
        .i_clr  (w_tx_launch && (r_tx_idx == 3'd0)),
        .i_en   (w_tx_launch && (r_tx_idx < (r_rep_len - 3'd2))),
        .i_data (w_tx_byte),
        .o_crc  (w_tx_crc)
    );

    // Transmit FSM: response gap, then one byte per start/busy handshake
    always_ff @(posedge CLK_10MHZ or posedge RST) begin
        if (RST) begin
            r_tx_state  <= TX_IDLE;
            r_gap_cnt   <= '0;
            r_tx_idx    <= 3'd0;
            r_rep_len   <= 3'd6;
            r_rep_b0    <= 8'h00;
            r_rep_b1    <= 8'h00;
            r_tx_data   <= 8'h00;
            r_tx_start  <= 1'b0;
            r_tx_busy_d <= 1'b0;
        end else begin
            r_tx_busy_d <= tx_busy;
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_reply_now) begin
                        r_rep_len  <= w_rep_len;
                        r_rep_b0   <= w_rep_b0;
                        r_rep_b1   <= w_rep_b1;
                        r_gap_cnt  <= '0;
                        r_tx_state <= TX_GAP;
                    end
                end
                TX_GAP: begin
                    if (r_gap_cnt == GAP_LAST) begin
                        r_tx_idx   <= 3'd0;
                        r_tx_state <= TX_SEND;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 1'b1;
                    end
                end
                TX_SEND: begin
                    if (r_tx_start) begin
                        if (tx_busy && !r_tx_busy_d) r_tx_start <= 1'b0;
                    end else if (!tx_busy && !r_tx_busy_d) begin
                        if (r_tx_idx == r_rep_len) begin
                            r_tx_state <= TX_IDLE;
                        end else begin
                            r_tx_data  <= w_tx_byte;
                            r_tx_start <= 1'b1;
                            r_tx_idx   <= r_tx_idx + 3'd1;
                        end
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    assign tx_data      = r_tx_data;
    assign tx_start     = r_tx_start;
    assign bv_state     = r_bv_state;
    assign bill_pending = r_pending;
    assign crc_err_cnt  = r_crc_err;

endmodule
